// File: rtl/uart_pkg.sv
// Shared definitions for the word-wide UART transmitter: state encoding and
// framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;
  localparam int unsigned BYTES_PER_WORD       = 4;
  localparam int unsigned BITS_PER_BYTE        = 8;

endpackage

// File: rtl/uart_tx_word_if.sv
// Write/serial signal bundle between a bus master and the word transmitter.
interface uart_tx_word_if;

  logic        enable;
  logic [31:0] D;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    output enable,
    output D,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  enable,
    input  D,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time counter: runs 0..ClksPerBit-1 and flags the terminal count.
module uart_baud_gen #(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LastCount = 16'(ClksPerBit - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LastCount);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_word.sv
// 8N1 UART transmitter sending a 32-bit word as four back-to-back bytes,
// LSB byte first, with a sticky overrun flag and a tristate status port.
module uart_tx_word
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_word_if.slave bus,
  input  logic          OE,
  output logic [31:0]   Q
);

  localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);
  localparam logic [2:0] LastBit  = 3'(BITS_PER_BYTE - 1);

  uart_state_e state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        tx_q, tx_d;
  logic        overrun_q, overrun_d;
  logic        tick;
  logic        clear;
  logic        busy;
  logic        done;

  // Counter is held at zero while idle so every state starts a fresh bit time.
  assign clear = (state_d != state_q) || (state_q == StIdle);

  uart_baud_gen #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_baud_gen (
    .clock(clock),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.enable) begin
          shift_d = bus.D;
          bit_d   = '0;
          byte_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          // Shifting the whole word leaves the next byte in [7:0] after bit 7.
          shift_d = {1'b0, shift_q[31:1]};
          if (bit_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (byte_q != LastByte) begin
            byte_d  = byte_q + 2'd1;
            state_d = StStart;
          end else begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // tx is registered from the upcoming state so the line changes on the edge
  // that enters each bit.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // A write landing on the final edge of a word still counts as a busy write.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.enable && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign bus.tx   = tx_q;
  assign bus.busy = busy;
  assign bus.done = done;

  assign Q = OE ? {30'b0, overrun_q, busy} : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_uart_tx_word.sv
// Self-checking bench for uart_tx_word: per-cycle reference model of the
// serial frame plus table-driven byte decoding and reset/overrun sequences.
module tb_uart_tx_word;

  localparam int N          = 4;
  localparam int WordCycles = 40 * N;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        oe    = 1'b1;
  wire  [31:0] q;

  uart_tx_word_if bus ();

  uart_tx_word #(
    .CLKS_PER_BIT(N)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus),
    .OE   (oe),
    .Q    (q)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state: word in flight and 1-based cycle index within it.
  bit          m_active = 1'b0;
  bit          m_ovr    = 1'b0;
  logic [31:0] m_word   = '0;
  int          m_k      = 0;
  logic        tx_log [1:WordCycles];
  int          done_cnt = 0;
  int          busy_cnt = 0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of cycle k (1..40N) of a word, straight from the 8N1 frame rule.
  function automatic logic model_tx(input logic [31:0] w, input int k);
    int idx;
    int b;
    int pos;
    idx = (k - 1) / N;
    b   = idx / 10;
    pos = idx % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[b * 8 + pos - 1];
  endfunction

  task automatic check_model();
    logic exp_tx;
    exp_tx = m_active ? model_tx(m_word, m_k) : 1'b1;
    check("tx", 32'(bus.tx), 32'(exp_tx));
    check("busy", 32'(bus.busy), 32'(m_active));
    check("done", 32'(bus.done), 32'(m_active && (m_k == WordCycles)));
    if (oe) check("status", q, {30'b0, m_ovr, m_active});
    if (m_active) tx_log[m_k] = bus.tx;
    if (bus.done) done_cnt++;
    if (bus.busy) busy_cnt++;
  endtask

  task automatic step(input logic en, input logic [31:0] d);
    bus.enable = en;
    bus.D      = d;
    @(posedge clock);
    if (!reset) begin
      m_active = 1'b0;
      m_ovr    = 1'b0;
    end else if (m_active) begin
      if (en) m_ovr = 1'b1;
      if (m_k == WordCycles) m_active = 1'b0;
      else m_k++;
    end else if (en) begin
      m_active = 1'b1;
      m_word   = d;
      m_k      = 1;
    end
    @(negedge clock);
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    m_active = 1'b0;
    m_ovr    = 1'b0;
    step(1'b1, $urandom);
    step(1'b0, $urandom);
    reset = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    done_cnt = 0;
    busy_cnt = 0;
    step(1'b1, w);
    repeat (WordCycles) step(1'b0, $urandom);
    check("done_count", 32'(done_cnt), 32'd1);
    check("busy_cycles", 32'(busy_cnt), 32'(WordCycles));
  endtask

  task automatic decode(input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_b [4];
    logic [7:0] got;
    exp_b[0] = e0;
    exp_b[1] = e1;
    exp_b[2] = e2;
    exp_b[3] = e3;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        got[i] = tx_log[(b * 10 + 1 + i) * N + N / 2 + 1];
      end
      check("start_bit", 32'(tx_log[b * 10 * N + N / 2 + 1]), 32'd0);
      check("stop_bit", 32'(tx_log[(b * 10 + 9) * N + N / 2 + 1]), 32'd1);
      check("byte", 32'(got), 32'(exp_b[b]));
    end
  endtask

  initial begin
    vecs[0] = '{word: 32'h44332211, b0: 8'h11, b1: 8'h22, b2: 8'h33, b3: 8'h44};
    vecs[1] = '{word: 32'h000000A5, b0: 8'hA5, b1: 8'h00, b2: 8'h00, b3: 8'h00};
    vecs[2] = '{word: 32'h80FF0155, b0: 8'h55, b1: 8'h01, b2: 8'hFF, b3: 8'h80};
    vecs[3] = '{word: 32'hC3B2A190, b0: 8'h90, b1: 8'hA1, b2: 8'hB2, b3: 8'hC3};

    bus.enable = 1'b0;
    bus.D      = '0;
    @(negedge clock);
    // Writes during reset must be ignored.
    do_reset();
    check("idle_status", q, 32'h0);
    oe = 1'b0;
    #1;
    checks++;
    if (!(q === 32'hzzzzzzzz)) begin
      errors++;
      $display("FAIL status_hiz: got %h expected zzzzzzzz", q);
    end
    oe = 1'b1;
    #1;
    check("status_oe", q, 32'h0);

    // Table-driven words, back to back.
    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v].word);
      decode(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
    end

    // Overrun mid-word: second word is dropped.
    do_reset();
    step(1'b1, 32'h000000A5);
    repeat (48) step(1'b0, $urandom);
    step(1'b1, 32'hFFFFFFFF);
    check("ovr_status", q, 32'h3);
    repeat (WordCycles - 49) step(1'b0, $urandom);
    decode(8'hA5, 8'h00, 8'h00, 8'h00);
    repeat (10) step(1'b0, $urandom);
    check("ovr_sticky", q, 32'h2);

    // Reset in the middle of a word aborts it immediately.
    do_reset();
    step(1'b1, 32'h12345678);
    repeat (69) step(1'b0, $urandom);
    check("mid_busy", 32'(bus.busy), 32'd1);
    do_reset();
    send_word(32'h44332211);
    decode(8'h11, 8'h22, 8'h33, 8'h44);

    // Write on the done cycle is an overrun; the next cycle's write is taken.
    do_reset();
    step(1'b1, 32'h0F0F0F0F);
    repeat (WordCycles - 1) step(1'b0, $urandom);
    check("done_cycle", 32'(bus.done), 32'd1);
    step(1'b1, 32'hDEADBEEF);
    check("late_ovr", q, 32'h2);
    send_word(32'hC3B2A190);
    decode(8'h90, 8'hA1, 8'hB2, 8'hC3);
    check("late_status", q, 32'h2);

    // Random words with random gaps and stray writes, against the model.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      step(1'b1, $urandom);
      repeat (WordCycles) step(($urandom_range(0, 49) == 0), $urandom);
      repeat ($urandom_range(0, 5)) step(1'b0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_word.md
UART_TX_WORD -- requirements
Module: uart_tx_word

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit time; legal range 2..65535.
REQ-002 clock  input  1  rising-edge system clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  bus write strobe; captures D when the block is idle.
REQ-005 D  input  32  word to transmit, sent as bytes D[7:0], D[15:8], D[23:16], D[31:24].
REQ-006 OE  input  1  status output enable.
REQ-007 Q  output  32  status word {30'b0, overrun, busy} when OE=1, else 32'hzzzzzzzz.
REQ-008 tx  output  1  serial line, 8N1, idle high.
REQ-009 busy  output  1  high while a word is in transmission.
REQ-010 done  output  1  one-cycle pulse when the last stop bit of the word completes.

Function
REQ-011 The state machine SHALL have states IDLE, START, DATA and STOP.
REQ-012 In IDLE, enable=1 at a rising edge SHALL capture D into a 32-bit shift register and enter START on that edge.
REQ-013 Each state SHALL be held for exactly CLKS_PER_BIT cycles, counted by a baud counter running 0..CLKS_PER_BIT-1 and cleared on every state change.
REQ-014 START SHALL drive tx=0 and then go to DATA with the bit count at 0.
REQ-015 DATA SHALL drive the current byte LSB first, 8 bits, and go to STOP after bit 7.
REQ-016 STOP SHALL drive tx=1; after the stop bit it SHALL go to START if the byte count is below 3 (count incremented), else to IDLE.
REQ-017 The frame for one byte SHALL be 10*CLKS_PER_BIT cycles; the frame for one word SHALL be exactly 40*CLKS_PER_BIT cycles, with no idle gap between bytes.
REQ-018 tx SHALL be registered; the start bit SHALL appear on the cycle after the capturing edge.
REQ-019 busy SHALL be high from the cycle after the capture to the cycle the state returns to IDLE, inclusive of the done cycle.
REQ-020 done SHALL pulse for one cycle, coincident with the return to IDLE.
REQ-021 enable=1 while not in IDLE SHALL be ignored for data and SHALL set the sticky overrun bit, which is cleared only by reset.
REQ-022 When the return to IDLE and enable=1 occur on the same edge, the write SHALL count as busy (overrun set, data dropped); it is accepted only from IDLE.
REQ-023 Q SHALL be combinational on OE and independent of the state machine.

Reset
REQ-024 reset=0 SHALL force, asynchronously, state=IDLE, tx=1, busy=0, done=0, overrun=0, and all counters and the shift register to 0.
REQ-025 Reset during a transmission SHALL abort the word immediately, with tx going to 1, and no done pulse.
REQ-026 The first capture after reset release SHALL occur no earlier than the first rising edge with reset=1.

Structure
REQ-027 A shared package uart_pkg SHALL hold the state encoding (2-bit type), the default CLKS_PER_BIT and the constant BYTES_PER_WORD=4.
REQ-028 The baud counter SHALL be a sub-module, uart_baud_gen, with inputs clock, reset and clear, and a tick output on the terminal count.
REQ-029 The implementation SHALL be 120-400 lines of RTL.

Verification (CLKS_PER_BIT=4)
REQ-030 Scenario: write D=32'h44332211 -> tx carries bytes 11, 22, 33, 44 in 8N1 format, done pulses after 160 cycles, and busy is high for 160 cycles.
REQ-031 Scenario: write D=32'h000000A5, then write 32'hFFFFFFFF at cycle 50 -> the bytes sent are A5, 00, 00, 00, the second word is never sent, and status with OE=1 reads 32'h00000003.
REQ-032 Scenario: pull reset low at cycle 70 of a word -> tx=1 and busy=0 immediately, no done pulse, and a new write then sends correctly.
REQ-033 Scenario: OE=0 -> Q=32'hzzzzzzzz; idle with OE=1 after reset -> Q=32'h00000000.
REQ-034 Scenario: write on the done cycle, then write again one cycle later -> the first write sets overrun, and the second write starts a full 160-cycle word.
